mem_lsu: RTL and testbench
==========================

MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 Parameter RAW, default 5: register-address width.
REQ-002 Parameter AW, default 32: data-bus address width.
REQ-003 Parameter TIMEOUT, default 16: maximum BUS-state cycles before a bus error (>=2).
REQ-004 Port clk  in  1: single clock; all state updates on rising edge.
REQ-005 Port rst  in  1: asynchronous, active-low reset.
REQ-006 Ports wd_i in RAW / wreg_i in 1 / wdata_i in 32: destination address, write-enable and result from the execute stage.
REQ-007 Ports valid_i in 1 / flush_i in 1: input instruction valid; squash current instruction.
REQ-008 Port memop_i  in  4: 0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; codes 9-15 are treated as NONE.
REQ-009 Ports maddr_i in AW / msdata_i in 32: memory address; raw store data.
REQ-010 Port stall_o  out  1: upstream holds all inputs stable while high.
REQ-011 Ports d_req_o out 1 / d_we_o out 1 / d_addr_o out AW / d_sel_o out 4 / d_wdata_o out 32: data-bus request.
REQ-012 Ports d_ack_i in 1 / d_rdata_i in 32: bus completion; read data is valid with ack.
REQ-013 Ports valid_o out 1 / wd_o out RAW / wreg_o out 1 / wdata_o out 32: registered writeback outputs.
REQ-014 Ports misalign_o out 1 / bus_err_o out 1: one-cycle exception pulses, aligned with valid_o.

Function
REQ-015 The FSM SHALL have two states: IDLE and BUS.
REQ-016 In IDLE, a valid_i with NONE op and no flush_i SHALL register wd_i, wreg_i and wdata_i to the outputs and set valid_o=1 on the next edge, giving 1-cycle latency.
REQ-017 In IDLE with valid_i=0 or flush_i=1, the next edge SHALL set valid_o=0 and wreg_o=0, and SHALL start no bus access.
REQ-018 Alignment: LH/LHU/SH SHALL require maddr_i[0]=0, and LW/SW SHALL require maddr_i[1:0]=0.
REQ-019 A misaligned op SHALL start no bus access, and the next edge SHALL set valid_o=1, misalign_o=1 and wreg_o=0.
REQ-020 An aligned memory op in IDLE SHALL assert stall_o combinationally, latch address/select/store-data/op/wd/wreg on the edge and enter BUS.
REQ-021 d_req_o SHALL equal (state==BUS), and d_addr_o/d_we_o/d_sel_o/d_wdata_o SHALL hold stable throughout BUS.
REQ-022 In BUS, stall_o SHALL equal !d_ack_i.
REQ-023 d_ack_i in BUS SHALL return the FSM to IDLE, update the writeback outputs and set valid_o=1 on that edge, for a minimum load/store latency of 2 cycles.
REQ-024 d_ack_i outside BUS SHALL be ignored.
REQ-025 d_sel_o little-endian: byte ops 1<<addr[1:0]; half ops addr[1] ? 1100 : 0011; word ops 1111.
REQ-026 d_wdata_o: SB replicates msdata_i[7:0] x4; SH replicates msdata_i[15:0] x2; SW passes msdata_i unchanged.
REQ-027 Loads SHALL extract the selected byte/half lane of d_rdata_i; LB/LH sign-extend and LBU/LHU zero-extend to 32 bits; wdata_o gets the result and wreg_o the latched wreg.
REQ-028 A store SHALL force wreg_o=0.
REQ-029 A counter SHALL clear on BUS entry and increment each BUS cycle without ack.
REQ-030 At count TIMEOUT-1 with no ack, the FSM SHALL return to IDLE with d_req_o dropping, valid_o=1, bus_err_o=1, wreg_o=0 and stall_o=0 in that cycle.
REQ-031 Ack and timeout in the same cycle: ack SHALL win, with no bus_err_o.
REQ-032 flush_i during BUS SHALL NOT abort the bus transaction; completion SHALL then set wreg_o=0 and valid_o=0.
REQ-033 misalign_o and bus_err_o SHALL be high for exactly one cycle per event.

Reset
REQ-034 While rst=0, the FSM SHALL be in IDLE, the counter 0, all outputs 0 and stall_o=0, regardless of clk.
REQ-035 Reset mid-BUS SHALL drop d_req_o immediately and discard the pending op; after deassertion the block SHALL accept new input on the first edge.

Verification
REQ-036 NONE op, wd_i=3, wreg_i=1, wdata_i=0x1234 -> next cycle valid_o=1, wd_o=3, wreg_o=1, wdata_o=0x1234, stall_o never high.
REQ-037 LB at address 0x103, ack after 3 wait cycles with rdata=0x80FFFFFF -> d_sel_o=1000, stall_o high 4 cycles, wdata_o=0xFFFFFF80; repeat with LBU -> wdata_o=0x00000080.
REQ-038 SH at address 0x202, msdata_i=0xABCD1234, immediate ack -> d_we_o=1, d_sel_o=1100, d_wdata_o=0x12341234, wreg_o=0.
REQ-039 LW at address 0x101 -> no d_req_o, misalign_o=1 and valid_o=1 for 1 cycle, wreg_o=0.
REQ-040 LW with no ack and TIMEOUT=16 -> d_req_o high 16 cycles, then bus_err_o=1 for 1 cycle and FSM back in IDLE; ack arriving on cycle 16 -> normal completion with no error.
REQ-041 Reset asserted mid-BUS -> d_req_o and stall_o go 0 asynchronously; next NONE op after release completes with 1-cycle latency.

Source files
------------

// File: rtl/mem_lsu_if.sv
// Data-bus bundle between the load/store unit (master) and memory (slave).
// Read data is valid in the cycle d_ack_i is high.
interface mem_lsu_if #(
    parameter int unsigned AW = 32
);
    logic          d_req_o;
    logic          d_we_o;
    logic [AW-1:0] d_addr_o;
    logic [3:0]    d_sel_o;
    logic [31:0]   d_wdata_o;
    logic          d_ack_i;
    logic [31:0]   d_rdata_i;

    modport master (
        output d_req_o, d_we_o, d_addr_o, d_sel_o, d_wdata_o,
        input  d_ack_i, d_rdata_i
    );

    modport slave (
        input  d_req_o, d_we_o, d_addr_o, d_sel_o, d_wdata_o,
        output d_ack_i, d_rdata_i
    );
endinterface

// File: rtl/mem_lsu.sv
// Memory stage: passes ALU results through in one cycle, or runs one aligned
// byte/half/word bus access with a timeout and returns a registered writeback.
module mem_lsu #(
    parameter int unsigned RAW     = 5,
    parameter int unsigned AW      = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [RAW-1:0] wd_i,
    input  logic           wreg_i,
    input  logic [31:0]    wdata_i,
    input  logic           valid_i,
    input  logic           flush_i,
    input  logic [3:0]     memop_i,
    input  logic [AW-1:0]  maddr_i,
    input  logic [31:0]    msdata_i,
    output logic           stall_o,
    mem_lsu_if.master      dbus,
    output logic           valid_o,
    output logic [RAW-1:0] wd_o,
    output logic           wreg_o,
    output logic [31:0]    wdata_o,
    output logic           misalign_o,
    output logic           bus_err_o
);
    localparam int unsigned CW = $clog2(TIMEOUT);
    localparam logic [3:0] OpLb = 4'd1, OpLbu = 4'd2, OpLh = 4'd3, OpLhu = 4'd4, OpLw = 4'd5;
    localparam logic [3:0] OpSb = 4'd6, OpSh = 4'd7, OpSw = 4'd8;

    typedef enum logic {StIdle, StBus} state_e;

    state_e          state_q;
    logic [CW-1:0]   cnt_q;
    logic [3:0]      op_q;
    logic [RAW-1:0]  wd_q;
    logic            wreg_q;
    logic            flushed_q;
    logic            we_q;
    logic [AW-1:0]   addr_q;
    logic [3:0]      sel_q;
    logic [31:0]     sdata_q;

    logic            is_mem, is_store, misaligned, accept, start_bus, timeout_hit, kill;
    logic [3:0]      sel_d;
    logic [31:0]     sdata_d, load_data;
    logic [7:0]      lane8;
    logic [15:0]     lane16;

    always_comb begin
        is_mem     = (memop_i >= OpLb) && (memop_i <= OpSw);
        is_store   = (memop_i >= OpSb) && (memop_i <= OpSw);
        misaligned = 1'b0;
        sel_d      = 4'b0000;
        sdata_d    = msdata_i;
        case (memop_i)
            OpLb, OpLbu, OpSb: sel_d = 4'b0001 << maddr_i[1:0];
            OpLh, OpLhu, OpSh: begin
                sel_d      = maddr_i[1] ? 4'b1100 : 4'b0011;
                misaligned = maddr_i[0];
            end
            OpLw, OpSw: begin
                sel_d      = 4'b1111;
                misaligned = |maddr_i[1:0];
            end
            default: ;
        endcase
        if (memop_i == OpSb) sdata_d = {4{msdata_i[7:0]}};
        if (memop_i == OpSh) sdata_d = {2{msdata_i[15:0]}};
        accept      = valid_i && !flush_i;
        start_bus   = (state_q == StIdle) && accept && is_mem && !misaligned;
        timeout_hit = (cnt_q == CW'(TIMEOUT - 1));
        kill        = flush_i || flushed_q;
        // Reset gating keeps stall low even while upstream holds a memory op.
        stall_o = rst && ((state_q == StIdle) ? start_bus : (!dbus.d_ack_i && !timeout_hit));
    end

    always_comb begin
        lane8  = 8'(dbus.d_rdata_i >> {addr_q[1:0], 3'b000});
        lane16 = addr_q[1] ? dbus.d_rdata_i[31:16] : dbus.d_rdata_i[15:0];
        case (op_q)
            OpLb:    load_data = {{24{lane8[7]}}, lane8};
            OpLbu:   load_data = {24'h0, lane8};
            OpLh:    load_data = {{16{lane16[15]}}, lane16};
            OpLhu:   load_data = {16'h0, lane16};
            OpLw:    load_data = dbus.d_rdata_i;
            default: load_data = 32'h0;
        endcase
    end

    assign dbus.d_req_o   = (state_q == StBus);
    assign dbus.d_we_o    = we_q;
    assign dbus.d_addr_o  = addr_q;
    assign dbus.d_sel_o   = sel_q;
    assign dbus.d_wdata_o = sdata_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            op_q       <= 4'h0;
            wd_q       <= '0;
            wreg_q     <= 1'b0;
            flushed_q  <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            sel_q      <= 4'h0;
            sdata_q    <= 32'h0;
            valid_o    <= 1'b0;
            wd_o       <= '0;
            wreg_o     <= 1'b0;
            wdata_o    <= 32'h0;
            misalign_o <= 1'b0;
            bus_err_o  <= 1'b0;
        end else begin
            misalign_o <= 1'b0;
            bus_err_o  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    wd_o    <= wd_i;
                    wdata_o <= wdata_i;
                    if (!accept) begin
                        valid_o <= 1'b0;
                        wreg_o  <= 1'b0;
                    end else if (!is_mem) begin
                        valid_o <= 1'b1;
                        wreg_o  <= wreg_i;
                    end else if (misaligned) begin
                        valid_o    <= 1'b1;
                        wreg_o     <= 1'b0;
                        misalign_o <= 1'b1;
                    end else begin
                        valid_o   <= 1'b0;
                        wreg_o    <= 1'b0;
                        state_q   <= StBus;
                        cnt_q     <= '0;
                        op_q      <= memop_i;
                        wd_q      <= wd_i;
                        wreg_q    <= wreg_i && !is_store;
                        flushed_q <= 1'b0;
                        we_q      <= is_store;
                        addr_q    <= maddr_i;
                        sel_q     <= sel_d;
                        sdata_q   <= sdata_d;
                    end
                end
                StBus: begin
                    if (flush_i) flushed_q <= 1'b1;
                    // Ack takes priority over the timeout in the same cycle.
                    if (dbus.d_ack_i || timeout_hit) begin
                        state_q   <= StIdle;
                        valid_o   <= !kill;
                        wd_o      <= wd_q;
                        wreg_o    <= dbus.d_ack_i && wreg_q && !kill;
                        wdata_o   <= dbus.d_ack_i ? load_data : 32'h0;
                        bus_err_o <= !dbus.d_ack_i && !kill;
                    end else begin
                        cnt_q   <= cnt_q + 1'b1;
                        valid_o <= 1'b0;
                        wreg_o  <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_lsu.sv
// Randomized bench for mem_lsu with a lane/extension model built from plain arithmetic.
module tb_mem_lsu;
    localparam int unsigned TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  wd_i = '0;
    logic        wreg_i = 1'b0;
    logic [31:0] wdata_i = '0;
    logic        valid_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [3:0]  memop_i = '0;
    logic [31:0] maddr_i = '0;
    logic [31:0] msdata_i = '0;
    logic        stall_o, valid_o, wreg_o, misalign_o, bus_err_o;
    logic [4:0]  wd_o;
    logic [31:0] wdata_o;
    int          errors = 0;
    int          checks = 0;

    mem_lsu_if #(.AW(32)) dbus ();

    mem_lsu #(.RAW(5), .AW(32), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
        .valid_i(valid_i), .flush_i(flush_i), .memop_i(memop_i), .maddr_i(maddr_i),
        .msdata_i(msdata_i), .stall_o(stall_o), .dbus(dbus), .valid_o(valid_o),
        .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .misalign_o(misalign_o),
        .bus_err_o(bus_err_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1);
    end

    function automatic bit m_is_mem(input logic [3:0] op);
        return op >= 1 && op <= 8;
    endfunction

    function automatic bit m_is_store(input logic [3:0] op);
        return op >= 6 && op <= 8;
    endfunction

    function automatic int unsigned m_size(input logic [3:0] op);
        if (op == 3 || op == 4 || op == 7) return 2;
        if (op == 5 || op == 8) return 4;
        return 1;
    endfunction

    function automatic logic [3:0] m_sel(input logic [3:0] op, input logic [31:0] addr);
        int unsigned sz = m_size(op);
        if (sz == 1) return 4'(1 << (addr % 4));
        if (sz == 2) return (addr % 4 >= 2) ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_sdata(input logic [3:0] op, input logic [31:0] s);
        if (op == 6) return (s & 32'hFF) * 32'h01010101;
        if (op == 7) return (s & 32'hFFFF) * 32'h00010001;
        return s;
    endfunction

    function automatic logic [31:0] m_load(input logic [3:0] op, input logic [31:0] addr,
                                           input logic [31:0] r);
        int unsigned sh = 8 * (addr % 4);
        logic [31:0] v = r;
        if (op == 1 || op == 2) begin
            v = (r >> sh) & 32'hFF;
            if (op == 1 && v >= 128) v = v + 32'hFFFFFF00;
        end else if (op == 3 || op == 4) begin
            v = (r >> sh) & 32'hFFFF;
            if (op == 3 && v >= 32768) v = v + 32'hFFFF0000;
        end
        return v;
    endfunction

    // Drives one instruction at posedge+1 and follows it to completion.
    // waits = ack-free bus cycles before ack; waits >= TIMEOUT means no ack at all.
    task automatic run_tx(input logic [3:0] op, input logic [31:0] addr, input logic [4:0] wd,
                          input logic wreg, input logic [31:0] wdata, input logic [31:0] sdata,
                          input logic [31:0] rdata, input int waits);
        bit mem = m_is_mem(op);
        bit mis = mem && (addr % m_size(op) != 0);
        logic exp_wreg;
        valid_i = 1; flush_i = 0; memop_i = op; maddr_i = addr; wd_i = wd; wreg_i = wreg;
        wdata_i = wdata; msdata_i = sdata; dbus.d_ack_i = 0;
        #1;
        if (!mem || mis) begin
            checks++; if (stall_o !== 1'b0) begin errors++;
                $display("FAIL pass_stall op=%0d: got %b exp 0", op, stall_o); end
            @(posedge clk); #1;
            valid_i = 0;
            exp_wreg = mem ? 1'b0 : wreg;
            checks++; if (valid_o !== 1'b1 || wreg_o !== exp_wreg || misalign_o !== mis ||
                          bus_err_o !== 1'b0 || dbus.d_req_o !== 1'b0) begin errors++;
                $display("FAIL pass_flags op=%0d: got v%b w%b m%b e%b r%b exp v1 w%b m%b e0 r0",
                         op, valid_o, wreg_o, misalign_o, bus_err_o, dbus.d_req_o, exp_wreg, mis); end
            if (!mem) begin
                checks++; if (wd_o !== wd || wdata_o !== wdata) begin errors++;
                    $display("FAIL pass_data: got %h/%h exp %h/%h", wd_o, wdata_o, wd, wdata); end
            end
            @(posedge clk); #1;
            checks++; if (valid_o !== 1'b0 || misalign_o !== 1'b0) begin errors++;
                $display("FAIL pass_pulse: got v%b m%b exp v0 m0", valid_o, misalign_o); end
            return;
        end
        checks++; if (stall_o !== 1'b1 || dbus.d_req_o !== 1'b0) begin errors++;
            $display("FAIL idle_stall op=%0d: got s%b r%b exp s1 r0", op, stall_o, dbus.d_req_o); end
        @(posedge clk); #1;
        checks++; if (dbus.d_we_o !== m_is_store(op) || dbus.d_addr_o !== addr ||
                      dbus.d_sel_o !== m_sel(op, addr) || valid_o !== 1'b0 ||
                      (m_is_store(op) && dbus.d_wdata_o !== m_sdata(op, sdata))) begin errors++;
            $display("FAIL bus_req op=%0d: got we%b a%h s%b d%h v%b exp we%b a%h s%b d%h v0",
                     op, dbus.d_we_o, dbus.d_addr_o, dbus.d_sel_o, dbus.d_wdata_o, valid_o,
                     m_is_store(op), addr, m_sel(op, addr), m_sdata(op, sdata)); end
        for (int i = 0; i < waits && i < int'(TIMEOUT); i++) begin
            checks++; if (dbus.d_req_o !== 1'b1 || stall_o !== (i != int'(TIMEOUT) - 1) ||
                          dbus.d_sel_o !== m_sel(op, addr)) begin errors++;
                $display("FAIL bus_wait%0d: got r%b s%b exp r1 s%b", i, dbus.d_req_o, stall_o,
                         i != int'(TIMEOUT) - 1); end
            @(posedge clk); #1;
        end
        if (waits >= int'(TIMEOUT)) begin
            valid_i = 0;
            checks++; if (bus_err_o !== 1'b1 || valid_o !== 1'b1 || wreg_o !== 1'b0 ||
                          dbus.d_req_o !== 1'b0) begin errors++;
                $display("FAIL timeout: got e%b v%b w%b r%b exp e1 v1 w0 r0",
                         bus_err_o, valid_o, wreg_o, dbus.d_req_o); end
        end else begin
            dbus.d_ack_i = 1; dbus.d_rdata_i = rdata;
            #1;
            checks++; if (stall_o !== 1'b0 || dbus.d_req_o !== 1'b1) begin errors++;
                $display("FAIL ack_stall: got s%b r%b exp s0 r1", stall_o, dbus.d_req_o); end
            @(posedge clk); #1;
            dbus.d_ack_i = 0; dbus.d_rdata_i = $urandom; valid_i = 0;
            exp_wreg = m_is_store(op) ? 1'b0 : wreg;
            checks++; if (valid_o !== 1'b1 || wreg_o !== exp_wreg || bus_err_o !== 1'b0 ||
                          dbus.d_req_o !== 1'b0 || wd_o !== wd) begin errors++;
                $display("FAIL done op=%0d: got v%b w%b e%b r%b wd%h exp v1 w%b e0 r0 wd%h",
                         op, valid_o, wreg_o, bus_err_o, dbus.d_req_o, wd_o, exp_wreg, wd); end
            if (!m_is_store(op)) begin
                checks++; if (wdata_o !== m_load(op, addr, rdata)) begin errors++;
                    $display("FAIL load op=%0d a=%h: got %h exp %h", op, addr, wdata_o,
                             m_load(op, addr, rdata)); end
            end
        end
        @(posedge clk); #1;
        checks++; if (bus_err_o !== 1'b0 || valid_o !== 1'b0) begin errors++;
            $display("FAIL after: got e%b v%b exp e0 v0", bus_err_o, valid_o); end
    endtask

    task automatic test_reset();
        rst = 0; valid_i = 1; memop_i = 5; maddr_i = 32'h100; dbus.d_ack_i = 0;
        dbus.d_rdata_i = 0;
        #2;
        checks++; if (stall_o !== 0 || dbus.d_req_o !== 0 || valid_o !== 0 || wreg_o !== 0 ||
                      misalign_o !== 0 || bus_err_o !== 0 || wdata_o !== 0 ||
                      dbus.d_sel_o !== 0) begin errors++;
            $display("FAIL reset_outs: got s%b r%b v%b w%b m%b e%b d%h sel%b exp all 0",
                     stall_o, dbus.d_req_o, valid_o, wreg_o, misalign_o, bus_err_o, wdata_o,
                     dbus.d_sel_o); end
        @(posedge clk); #1;
        checks++; if (stall_o !== 0 || dbus.d_req_o !== 0 || valid_o !== 0) begin errors++;
            $display("FAIL reset_hold: got s%b r%b v%b exp 0", stall_o, dbus.d_req_o, valid_o); end
        valid_i = 0;
        @(negedge clk); rst = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_idle_drop();
        valid_i = 1; flush_i = 1; memop_i = 5; maddr_i = 32'h40; wreg_i = 1;
        @(posedge clk); #1;
        checks++; if (valid_o !== 0 || wreg_o !== 0 || dbus.d_req_o !== 0) begin errors++;
            $display("FAIL idle_flush: got v%b w%b r%b exp 0", valid_o, wreg_o, dbus.d_req_o); end
        flush_i = 0; valid_i = 0;
        @(posedge clk); #1;
        checks++; if (valid_o !== 0 || wreg_o !== 0 || dbus.d_req_o !== 0) begin errors++;
            $display("FAIL idle_invalid: got v%b w%b r%b exp 0", valid_o, wreg_o, dbus.d_req_o); end
    endtask

    task automatic test_ack_outside_bus();
        valid_i = 0; dbus.d_ack_i = 1;
        @(posedge clk); #1;
        checks++; if (valid_o !== 0 || dbus.d_req_o !== 0) begin errors++;
            $display("FAIL stray_ack: got v%b r%b exp 0", valid_o, dbus.d_req_o); end
        valid_i = 1; memop_i = 0; wd_i = 9; wreg_i = 1; wdata_i = 32'h55AA;
        @(posedge clk); #1;
        checks++; if (valid_o !== 1 || wreg_o !== 1 || wdata_o !== 32'h55AA) begin errors++;
            $display("FAIL stray_ack_none: got v%b w%b d%h exp v1 w1 d000055aa",
                     valid_o, wreg_o, wdata_o); end
        valid_i = 0; dbus.d_ack_i = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_flush_in_bus();
        valid_i = 1; memop_i = 5; maddr_i = 32'h40; wd_i = 4; wreg_i = 1;
        @(posedge clk); #1;
        flush_i = 1;
        @(posedge clk); #1;
        flush_i = 0;
        checks++; if (dbus.d_req_o !== 1) begin errors++;
            $display("FAIL flush_keeps_bus: got r%b exp r1", dbus.d_req_o); end
        dbus.d_ack_i = 1; dbus.d_rdata_i = 32'h12345678;
        @(posedge clk); #1;
        dbus.d_ack_i = 0; valid_i = 0;
        checks++; if (valid_o !== 0 || wreg_o !== 0 || dbus.d_req_o !== 0 ||
                      bus_err_o !== 0) begin errors++;
            $display("FAIL flush_done: got v%b w%b r%b e%b exp 0", valid_o, wreg_o,
                     dbus.d_req_o, bus_err_o); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_bus();
        valid_i = 1; memop_i = 5; maddr_i = 32'h80; wreg_i = 1;
        @(posedge clk); #1;
        checks++; if (dbus.d_req_o !== 1) begin errors++;
            $display("FAIL rmb_enter: got r%b exp 1", dbus.d_req_o); end
        #2 rst = 0;
        #1;
        checks++; if (dbus.d_req_o !== 0 || stall_o !== 0 || valid_o !== 0) begin errors++;
            $display("FAIL rmb_async: got r%b s%b v%b exp 0", dbus.d_req_o, stall_o, valid_o); end
        memop_i = 0; wd_i = 7; wreg_i = 1; wdata_i = 32'hCAFE;
        #1 rst = 1;
        @(posedge clk); #1;
        checks++; if (valid_o !== 1 || wd_o !== 7 || wreg_o !== 1 || wdata_o !== 32'hCAFE ||
                      dbus.d_req_o !== 0) begin errors++;
            $display("FAIL rmb_next: got v%b wd%h w%b d%h r%b exp v1 wd07 w1 d0000cafe r0",
                     valid_o, wd_o, wreg_o, wdata_o, dbus.d_req_o); end
        valid_i = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        run_tx(4'd0, 32'h0, 5'd3, 1'b1, 32'h1234, 32'h0, 32'h0, 0);
        run_tx(4'd1, 32'h103, 5'd5, 1'b1, 32'h0, 32'h0, 32'h80FFFFFF, 3);
        run_tx(4'd2, 32'h103, 5'd5, 1'b1, 32'h0, 32'h0, 32'h80FFFFFF, 3);
        run_tx(4'd7, 32'h202, 5'd6, 1'b1, 32'h0, 32'hABCD1234, 32'h0, 0);
        run_tx(4'd5, 32'h101, 5'd8, 1'b1, 32'h0, 32'h0, 32'h0, 0);
        run_tx(4'd5, 32'h100, 5'd8, 1'b1, 32'h0, 32'h0, 32'h0, int'(TIMEOUT));
        run_tx(4'd5, 32'h100, 5'd8, 1'b1, 32'h0, 32'h0, 32'hDEADBEEF, int'(TIMEOUT) - 1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            run_tx(4'($urandom_range(0, 15)), $urandom, 5'($urandom), 1'($urandom), $urandom,
                   $urandom, $urandom, int'($urandom_range(0, 4)));
        end
    endtask

    initial begin
        test_reset();
        test_idle_drop();
        test_directed();
        test_ack_outside_bus();
        test_flush_in_bus();
        test_reset_mid_bus();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
